// File: rtl/pkt_injector_pkg.sv
// Shared definitions for the packet injector: default widths, input fifo depth
// and the arbitration/framing state encoding.
package pkt_injector_pkg;

    localparam int DEF_DATA_WIDTH     = 64;
    localparam int DEF_BUF_ADDR_WIDTH = 8;
    localparam int IN_FIFO_DEPTH      = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_INJECT
    } inj_state_e;

endpackage

// File: rtl/pkt_injector_if.sv
// Datapath word stream (data/ctrl/wr forward, rdy backward) between stages.
interface pkt_injector_if
    import pkt_injector_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);

    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, ctrl, wr, input rdy);
    modport slave  (input data, ctrl, wr, output rdy);

endinterface

// File: rtl/pkt_injector_inject_buf.sv
// Injection buffer: simple dual-port RAM, CPU write port and registered read port.
module inject_buf
    import pkt_injector_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_DATA_WIDTH + DEF_DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = DEF_BUF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0] rd_data
);

    logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pkt_injector.sv
// Merges CPU-built packets from the injection buffer into the upstream word
// stream at packet boundaries; upstream words wait in a small input fifo.
module pkt_injector
    import pkt_injector_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int BUF_ADDR_WIDTH = DEF_BUF_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    pkt_injector_if.slave                    in_if,
    pkt_injector_if.master                   out_if,
    input  logic                             cpu_wr_en,
    input  logic [BUF_ADDR_WIDTH-1:0]        cpu_wr_addr,
    input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] cpu_wr_data,
    input  logic [BUF_ADDR_WIDTH:0]          cpu_pkt_len,
    input  logic                             cpu_send,
    output logic                             inj_busy,
    output logic                             inj_err,
    output logic [31:0]                      inj_pkt_cnt
);

    localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;
    localparam int LEN_W  = BUF_ADDR_WIDTH + 1;
    localparam int FA     = $clog2(IN_FIFO_DEPTH);
    localparam int CNT_W  = FA + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {BUF_ADDR_WIDTH{1'b0}}};

    // Input fall-through fifo
    logic [WORD_W-1:0] fifo_mem [IN_FIFO_DEPTH];
    logic [FA-1:0]     fifo_wp, fifo_rp;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty, fifo_pop;
    logic [WORD_W-1:0] fifo_head;
    logic [CTRL_WIDTH-1:0] head_ctrl;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_head  = fifo_mem[fifo_rp];
    assign head_ctrl  = fifo_head[WORD_W-1 -: CTRL_WIDTH];
    assign in_if.rdy  = (fifo_cnt < CNT_W'(IN_FIFO_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (in_if.wr) begin
            fifo_mem[fifo_wp] <= {in_if.ctrl, in_if.data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (in_if.wr) fifo_wp <= fifo_wp + FA'(1);
            if (fifo_pop) fifo_rp <= fifo_rp + FA'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(in_if.wr) - CNT_W'(fifo_pop);
        end
    end

    // Injection buffer; read address runs one word ahead so a stored word is
    // ready on every out_rdy cycle without bubbles.
    logic [BUF_ADDR_WIDTH-1:0] rd_ptr, rd_ptr_next;
    logic [WORD_W-1:0]         ram_q;

    inject_buf #(
        .WORD_WIDTH (WORD_W),
        .ADDR_WIDTH (BUF_ADDR_WIDTH)
    ) u_inject_buf (
        .clk     (clk),
        .wr_en   (cpu_wr_en && !inj_busy),
        .wr_addr (cpu_wr_addr),
        .wr_data (cpu_wr_data),
        .rd_addr (rd_ptr_next),
        .rd_data (ram_q)
    );

    logic [LEN_W-1:0] len_q;
    logic             send_ok;

    assign send_ok = cpu_send && !inj_busy && (cpu_pkt_len != '0) && (cpu_pkt_len <= MAX_LEN);

    inj_state_e        state, state_next;
    logic              seen_zero, seen_zero_next;
    logic              emit, inj_done;
    logic [WORD_W-1:0] emit_word;

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next     = state;
        seen_zero_next = seen_zero;
        fifo_pop       = 1'b0;
        emit           = 1'b0;
        inj_done       = 1'b0;
        emit_word      = fifo_head;
        rd_ptr_next    = (state == ST_INJECT) ? rd_ptr : '0;
        unique case (state)
            ST_IDLE: begin
                if (inj_busy) begin
                    state_next = ST_INJECT;
                end else if (!fifo_empty && out_if.rdy) begin
                    fifo_pop = 1'b1;
                    emit     = 1'b1;
                    if (head_ctrl != '0) begin
                        state_next     = ST_PASS;
                        seen_zero_next = 1'b0;
                    end
                end
            end
            ST_PASS: begin
                if (!fifo_empty && out_if.rdy) begin
                    fifo_pop = 1'b1;
                    emit     = 1'b1;
                    if (head_ctrl == '0)  seen_zero_next = 1'b1;
                    else if (seen_zero)   state_next     = ST_IDLE;
                end
            end
            ST_INJECT: begin
                emit_word = ram_q;
                if (out_if.rdy) begin
                    emit = 1'b1;
                    if ({1'b0, rd_ptr} == len_q - LEN_W'(1)) begin
                        inj_done   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        rd_ptr_next = rd_ptr + BUF_ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            seen_zero   <= 1'b0;
            rd_ptr      <= '0;
            len_q       <= '0;
            inj_busy    <= 1'b0;
            inj_err     <= 1'b0;
            inj_pkt_cnt <= '0;
            out_if.wr   <= 1'b0;
            out_if.data <= '0;
            out_if.ctrl <= '0;
        end else begin
            seen_zero <= seen_zero_next;
            rd_ptr    <= rd_ptr_next;
            if (send_ok) begin
                len_q    <= cpu_pkt_len;
                inj_busy <= 1'b1;
            end else if (inj_done) begin
                inj_busy <= 1'b0;
            end
            if (cpu_send && !send_ok) inj_err <= 1'b1;
            if (inj_done) inj_pkt_cnt <= inj_pkt_cnt + 32'd1;
            out_if.wr <= emit;
            if (emit) {out_if.ctrl, out_if.data} <= emit_word;
        end
    end

endmodule

// File: tb/tb_pkt_injector.sv
// Self-checking bench for pkt_injector: scenario tasks compare the observed
// output stream against packet-order expectations built in the bench.
module tb_pkt_injector;
    import pkt_injector_pkg::*;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int AW = 8;
    localparam int WW = DW + CW;

    typedef logic [WW-1:0] word_t;
    typedef word_t wq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pkt_injector_if #(.DATA_WIDTH(DW)) in_if();
    pkt_injector_if #(.DATA_WIDTH(DW)) out_if();

    logic          cpu_wr_en = 1'b0;
    logic [AW-1:0] cpu_wr_addr = '0;
    logic [WW-1:0] cpu_wr_data = '0;
    logic [AW:0]   cpu_pkt_len = '0;
    logic          cpu_send = 1'b0;
    logic          inj_busy, inj_err;
    logic [31:0]   inj_pkt_cnt;

    pkt_injector #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .BUF_ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_if       (in_if),
        .out_if      (out_if),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_pkt_len (cpu_pkt_len),
        .cpu_send    (cpu_send),
        .inj_busy    (inj_busy),
        .inj_err     (inj_err),
        .inj_pkt_cnt (inj_pkt_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_cnt = 0;
    word_t obs_q[$];
    int    obs_cyc[$];
    int    drv_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_if.wr) begin
            obs_q.push_back({out_if.ctrl, out_if.data});
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mk_pkt(input int n, input logic [CW-1:0] eop_ctrl, output wq_t q);
        q.delete();
        for (int i = 0; i < n; i++) begin
            logic [CW-1:0] c;
            c = (i == 0) ? 8'hFF : ((i == n - 1) ? eop_ctrl : 8'h00);
            q.push_back({c, $urandom, $urandom});
        end
    endtask

    task automatic load_buf(input wq_t words);
        foreach (words[i]) begin
            cpu_wr_en   = 1'b1;
            cpu_wr_addr = AW'(i);
            cpu_wr_data = words[i];
            tick();
        end
        cpu_wr_en = 1'b0;
    endtask

    task automatic send(input int len);
        cpu_pkt_len = 9'(len);
        cpu_send    = 1'b1;
        tick();
        cpu_send    = 1'b0;
    endtask

    task automatic send_upstream(input wq_t words, input int send_at, input int send_len, output bit ok);
        ok = 1'b1;
        drv_cyc.delete();
        foreach (words[i]) begin
            int k = 0;
            while (!in_if.rdy && k < 100) begin
                tick();
                k++;
            end
            if (!in_if.rdy) ok = 1'b0;
            in_if.wr = 1'b1;
            {in_if.ctrl, in_if.data} = words[i];
            if (i == send_at) begin
                cpu_pkt_len = 9'(send_len);
                cpu_send    = 1'b1;
            end
            drv_cyc.push_back(cyc);
            tick();
            in_if.wr = 1'b0;
            cpu_send = 1'b0;
        end
    endtask

    task automatic wait_out(input int n, input int budget, output bit ok);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (obs_q.size() >= n);
        repeat (6) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        obs_q.delete();
        obs_cyc.delete();
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_if.wr = 1'b0;
        out_if.rdy = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        checks++; if (out_if.wr !== 1'b0) begin errors++; $display("FAIL reset_out_wr: got %b expected 0", out_if.wr); end
        checks++; if (out_if.data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_if.data); end
        checks++; if (inj_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", inj_busy); end
        checks++; if (inj_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", inj_err); end
        checks++; if (inj_pkt_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", inj_pkt_cnt); end
        tick();
        reset = 1'b1;
        tick();
        checks++; if (in_if.rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b expected 1", in_if.rdy); end
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_pass();
        wq_t up;
        bit ok;
        logic [CW-1:0] ctl [9] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
        for (int i = 0; i < 9; i++) up.push_back({ctl[i], $urandom, $urandom});
        send_upstream(up, -1, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pass_in_rdy: got 0 expected 1"); end
        wait_out(9, 50, ok);
        checks++; if (obs_q.size() != 9) begin errors++; $display("FAIL pass_count: got %0d expected 9", obs_q.size()); end
        for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== up[i]) begin errors++; $display("FAIL pass_word[%0d]: got %h expected %h", i, obs_q[i], up[i]); end
            checks++; if (obs_cyc[i] != drv_cyc[i] + 2) begin errors++; $display("FAIL pass_latency[%0d]: got cycle %0d expected %0d", i, obs_cyc[i], drv_cyc[i] + 2); end
        end
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_inject();
        wq_t pkt;
        bit ok;
        mk_pkt(5, 8'h04, pkt);
        load_buf(pkt);
        send(5);
        checks++; if (inj_busy !== 1'b1) begin errors++; $display("FAIL inject_busy_set: got %b expected 1", inj_busy); end
        exp_cnt++;
        wait_out(5, 40, ok);
        checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL inject_count: got %0d expected 5", obs_q.size()); end
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== pkt[i]) begin errors++; $display("FAIL inject_word[%0d]: got %h expected %h", i, obs_q[i], pkt[i]); end
        end
        checks++; if (inj_busy !== 1'b0) begin errors++; $display("FAIL inject_busy_clr: got %b expected 0", inj_busy); end
        checks++; if (inj_pkt_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL inject_cnt: got %0d expected %0d", inj_pkt_cnt, exp_cnt); end
        obs_q.delete();
        obs_cyc.delete();
    endtask

    // first_up: whether the upstream packet must appear before the injected one
    task automatic test_order(input string name, input int up_len, input int inj_len, input int send_at, input bit first_up);
        wq_t up, pkt, exp;
        bit ok;
        mk_pkt(inj_len, 8'h10, pkt);
        load_buf(pkt);
        mk_pkt(up_len, 8'h80, up);
        send_upstream(up, send_at, inj_len, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_in_rdy: got 0 expected 1", name); end
        exp_cnt++;
        if (first_up) begin
            exp = up;
            foreach (pkt[i]) exp.push_back(pkt[i]);
        end else begin
            exp = pkt;
            foreach (up[i]) exp.push_back(up[i]);
        end
        wait_out(exp.size(), 100, ok);
        checks++; if (obs_q.size() != exp.size()) begin errors++; $display("FAIL %s_count: got %0d expected %0d", name, obs_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp[i]) begin errors++; $display("FAIL %s_word[%0d]: got %h expected %h", name, i, obs_q[i], exp[i]); end
        end
        checks++; if (inj_pkt_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL %s_cnt: got %0d expected %0d", name, inj_pkt_cnt, exp_cnt); end
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_err();
        int bad [2] = '{0, 257};
        wq_t pkt;
        bit ok;
        foreach (bad[b]) begin
            do_reset();
            checks++; if (inj_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", inj_err); end
            send(bad[b]);
            checks++; if (inj_err !== 1'b1) begin errors++; $display("FAIL err_len%0d: got %b expected 1", bad[b], inj_err); end
            repeat (10) tick();
            checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL err_len%0d_words: got %0d expected 0", bad[b], obs_q.size()); end
            checks++; if (inj_pkt_cnt !== 32'd0) begin errors++; $display("FAIL err_len%0d_cnt: got %0d expected 0", bad[b], inj_pkt_cnt); end
            checks++; if (inj_busy !== 1'b0) begin errors++; $display("FAIL err_len%0d_busy: got %b expected 0", bad[b], inj_busy); end
        end
        do_reset();
        mk_pkt(3, 8'h08, pkt);
        load_buf(pkt);
        out_if.rdy = 1'b0;
        send(3);
        exp_cnt++;
        for (int i = 0; i < 3; i++) begin
            cpu_wr_en   = 1'b1;
            cpu_wr_addr = AW'(i);
            cpu_wr_data = {8'h55, $urandom, $urandom};
            tick();
        end
        cpu_wr_en = 1'b0;
        send(2);
        checks++; if (inj_err !== 1'b1) begin errors++; $display("FAIL err_busy: got %b expected 1", inj_err); end
        out_if.rdy = 1'b1;
        wait_out(3, 40, ok);
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL err_busy_count: got %0d expected 3", obs_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== pkt[i]) begin errors++; $display("FAIL err_busy_word[%0d]: got %h expected %h", i, obs_q[i], pkt[i]); end
        end
        checks++; if (inj_pkt_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL err_busy_cnt: got %0d expected %0d", inj_pkt_cnt, exp_cnt); end
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_random_full();
        wq_t pkt;
        int k;
        for (int i = 0; i < 256; i++) pkt.push_back({8'($urandom), $urandom, $urandom});
        load_buf(pkt);
        send(256);
        exp_cnt++;
        k = 0;
        while (inj_busy && k < 3000) begin
            out_if.rdy = 1'($urandom % 2);
            tick();
            k++;
        end
        out_if.rdy = 1'b1;
        checks++; if (inj_busy !== 1'b0) begin errors++; $display("FAIL full_timeout: busy %b expected 0", inj_busy); end
        repeat (4) tick();
        checks++; if (obs_q.size() != 256) begin errors++; $display("FAIL full_count: got %0d expected 256", obs_q.size()); end
        for (int i = 0; i < 256 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== pkt[i]) begin errors++; $display("FAIL full_word[%0d]: got %h expected %h", i, obs_q[i], pkt[i]); end
        end
        checks++; if (inj_pkt_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL full_cnt: got %0d expected %0d", inj_pkt_cnt, exp_cnt); end
        send(256);
        for (int i = 0; i < 40; i++) begin
            out_if.rdy = 1'($urandom % 2);
            tick();
        end
        checks++; if (inj_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", inj_busy); end
        out_if.rdy = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_if.wr !== 1'b0) begin errors++; $display("FAIL abort_out_wr: got %b expected 0", out_if.wr); end
        checks++; if (inj_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", inj_busy); end
        #4;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        in_if.wr   = 1'b0;
        in_if.data = '0;
        in_if.ctrl = '0;
        out_if.rdy = 1'b1;
        test_reset();
        test_pass();
        test_inject();
        test_order("mid_send", 8, 4, 3, 1'b1);
        test_order("same_cycle", 3, 3, 0, 1'b0);
        test_err();
        test_random_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
